fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one FIFO write port among NREQ producers. It accepts words over per-requester valid/ready handshakes and drives the FIFO's wr/data_in directly, throttling on fifo_full. It optionally holds a grant for short bursts and latches FIFO overflow as a sticky error that blocks further writes. It sits between the producer blocks and the 16-deep, 8-bit FIFO.

---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NREQ producers
// Optional burst grant hold is compiled in with FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  input  logic                    fifo_threshold,
  input  logic                    fifo_overflow,
  output logic                    fifo_wr,
  output logic [DW-1:0]           fifo_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    err_overflow
);

  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR  = 2'd2;
`ifdef FIFO_ARB_BURST_EN
  localparam logic [1:0] ST_LOCK = 2'd1;
  localparam int CW = $clog2(BURST + 1);
  logic [CW-1:0] burst_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = fifo_threshold ^ (BURST > 0);
`endif

  logic [1:0]    state;
  logic [IW-1:0] last_ptr;
  logic          err_q;

  logic [IW:0]   cand;
  logic [IW-1:0] winner;
  logic          found;
  logic [IW-1:0] sel;
  logic          sel_valid;
  logic          xfer;

  // Round-robin scan starting just after the last served requester
  always_comb begin
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req_valid[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel       = '0;
    sel_valid = 1'b0;
    if (rst_n && state != ST_ERR) begin
`ifdef FIFO_ARB_BURST_EN
      if (state == ST_LOCK) begin
        sel       = last_ptr;
        sel_valid = req_valid[last_ptr];
      end else begin
        sel       = winner;
        sel_valid = found;
      end
`else
      sel       = winner;
      sel_valid = found;
`endif
      if (sel_valid && !fifo_full) req_ready[sel] = 1'b1;
    end
  end

  assign xfer         = |(req_valid & req_ready);
  assign fifo_wr      = xfer;
  assign fifo_data    = xfer ? req_data[int'(sel)*DW +: DW] : '0;
  assign grant_id     = xfer ? sel : '0;
  assign err_overflow = err_q & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_ptr <= IW'(NREQ - 1);
      err_q    <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      if (xfer) last_ptr <= sel;
      // Overflow wins over any lock bookkeeping; the current transfer still completes
      if (fifo_overflow) begin
        state <= ST_ERR;
        err_q <= 1'b1;
`ifdef FIFO_ARB_BURST_EN
        burst_cnt <= '0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
`ifdef FIFO_ARB_BURST_EN
            if (xfer && BURST > 1 && !fifo_threshold) begin
              state     <= ST_LOCK;
              burst_cnt <= CW'(1);
            end
`endif
          end
`ifdef FIFO_ARB_BURST_EN
          ST_LOCK: begin
            if (!req_valid[last_ptr]) begin
              state     <= ST_IDLE;
              burst_cnt <= '0;
            end else if (xfer) begin
              if (int'(burst_cnt) + 1 >= BURST || fifo_threshold) begin
                state     <= ST_IDLE;
                burst_cnt <= '0;
              end else begin
                burst_cnt <= burst_cnt + CW'(1);
              end
            end
          end
`endif
          default: state <= ST_ERR;
        endcase
      end
    end
  end

endmodule
